frame_fetch_ctrl: RTL

FRAME_FETCH_CTRL -- requirements
Module: frame_fetch_ctrl

---
 rtl/frame_fetch_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/frame_fetch_ctrl.sv
// Framebuffer fetch controller: reads one frame over Wishbone incrementing bursts
// into a show-ahead pixel FIFO that the display drains one word per pix_rd.
module frame_fetch_ctrl #(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          FIFO_DEPTH = 256,
  parameter int          BURST_LEN  = 16
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        enable,
  input  logic        frame_start,
  input  logic        pix_rd,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  output logic        underflow,
  output logic        busy,
  output logic [31:0] wb_adr,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic [31:0] wb_dat_sm,
  input  logic        wb_ack
);

  localparam int TOTAL = HDISP * VDISP;
  localparam int IDX_W = $clog2(TOTAL) + 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LEN_W = $clog2(BURST_LEN) + 1;

  typedef enum logic [2:0] {IDLE, WAIT_SOF, REQ, BURST, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] word_idx;
  logic [OCC_W-1:0] occupancy;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LEN_W-1:0] beats_left;
  logic             resync_pend;
  logic [31:0]      fifo_mem [FIFO_DEPTH];

  logic             push;
  logic             pop;
  logic             last_beat;
  logic [IDX_W-1:0] remaining;
  logic [LEN_W-1:0] next_len;
  logic [OCC_W-1:0] free_space;

  assign push       = wb_cyc & wb_ack;
  assign pop        = pix_rd & pix_valid;
  assign pix_valid  = (occupancy != '0);
  assign pix_data   = pix_valid ? fifo_mem[rd_ptr][23:0] : 24'h0;
  assign busy       = (state != IDLE) && (state != DONE);
  assign last_beat  = push && (beats_left == LEN_W'(1));
  assign remaining  = IDX_W'(TOTAL) - word_idx;
  assign next_len   = (remaining < IDX_W'(BURST_LEN)) ? LEN_W'(remaining) : LEN_W'(BURST_LEN);
  assign free_space = OCC_W'(FIFO_DEPTH) - occupancy;

  assign wb_we  = 1'b0;
  assign wb_sel = 4'hF;
  assign wb_bte = 2'b00;

  always_ff @(posedge pixel_clk) begin
    if (push) fifo_mem[wr_ptr] <= wb_dat_sm;
  end

  // Default FIFO/bus bookkeeping comes first; flushes later in the block override it.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state       <= IDLE;
      word_idx    <= '0;
      occupancy   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      beats_left  <= '0;
      resync_pend <= 1'b0;
      underflow   <= 1'b0;
      wb_adr      <= BASE_ADDR;
      wb_cyc      <= 1'b0;
      wb_stb      <= 1'b0;
      wb_cti      <= 3'b000;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      occupancy <= occupancy + OCC_W'(1);
      else if (pop && !push) occupancy <= occupancy - OCC_W'(1);
      if (pix_rd && !pix_valid) underflow <= 1'b1;
      if (push) begin
        word_idx   <= word_idx + IDX_W'(1);
        wb_adr     <= wb_adr + 32'd4;
        beats_left <= beats_left - LEN_W'(1);
      end

      if (!enable && state != BURST) begin
        state       <= IDLE;
        resync_pend <= 1'b0;
        occupancy   <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
      end else begin
        case (state)
          IDLE: state <= WAIT_SOF;
          WAIT_SOF, DONE: begin
            if (frame_start) begin
              state       <= REQ;
              word_idx    <= '0;
              underflow   <= 1'b0;
              resync_pend <= 1'b0;
              occupancy   <= '0;
              wr_ptr      <= '0;
              rd_ptr      <= '0;
            end
          end
          REQ: begin
            // No burst is in flight here, so a resync can be honoured at once.
            if (frame_start || resync_pend) begin
              word_idx    <= '0;
              underflow   <= 1'b0;
              resync_pend <= 1'b0;
              occupancy   <= '0;
              wr_ptr      <= '0;
              rd_ptr      <= '0;
            end else if (word_idx == IDX_W'(TOTAL)) begin
              state <= DONE;
            end else if (free_space >= OCC_W'(BURST_LEN)) begin
              state      <= BURST;
              wb_cyc     <= 1'b1;
              wb_stb     <= 1'b1;
              wb_adr     <= BASE_ADDR + {30'(word_idx), 2'b00};
              beats_left <= next_len;
              wb_cti     <= (next_len == LEN_W'(1)) ? 3'b111 : 3'b010;
            end
          end
          BURST: begin
            if (last_beat) begin
              wb_cyc <= 1'b0;
              wb_stb <= 1'b0;
              wb_cti <= 3'b000;
              if (!enable) begin
                state       <= IDLE;
                resync_pend <= 1'b0;
                occupancy   <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
              end else begin
                state <= REQ;
                if (resync_pend || frame_start) begin
                  word_idx    <= '0;
                  underflow   <= 1'b0;
                  resync_pend <= 1'b0;
                  occupancy   <= '0;
                  wr_ptr      <= '0;
                  rd_ptr      <= '0;
                end
              end
            end else begin
              if (frame_start) resync_pend <= 1'b1;
              if (push && beats_left == LEN_W'(2)) wb_cti <= 3'b111;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
